lfsr_stream_decoder: RTL and testbench
======================================

// Module: lfsr_stream_decoder
// PURPOSE
//  Receive-side decryptor for the secure keyboard link. Accepts the encrypted serial bit
//  stream, XORs each accepted bit with a 16-bit LFSR keystream identical to the encoder's,
//  and packs the plaintext bits into bytes for the host interface.
//  A 1-entry output register with a valid/ready handshake feeds the host.
//  Sits between the link bit receiver and the host-side keycode FIFO.
// PARAMETERS
//  SEED_DEFAULT  16'h009C  LFSR value after reset; also replaces any all-zero seed_in
//  DATA_W        8         plaintext word width, in bits
// PORTS
//  clk        in   1       system clock; all state changes on posedge
//  reset      in   1       asynchronous, active-low reset
//  seed_load  in   1       1-cycle pulse: load seed_in and restart word framing
//  seed_in    in   16      new LFSR seed, sampled while seed_load=1
//  bit_valid  in   1       bit_in is valid this cycle; accepted unconditionally
//  bit_in     in   1       encrypted serial bit
//  out_ready  in   1       host accepts byte_out this cycle when byte_valid=1
//  byte_out   out  DATA_W  decrypted word, LSB = first received bit
//  byte_valid out  1       byte_out holds an unconsumed word
//  overrun    out  1       sticky: a completed word was dropped; cleared only by reset or seed_load
// BEHAVIOUR
//  Reset (reset=0, async):
//   - lfsr=SEED_DEFAULT, bit_cnt=0, shift reg=0
//   - byte_out=0, byte_valid=0, overrun=0
//  LFSR:
//   - ks = lfsr[15]; fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]; next = {lfsr[14:0], fb}
//   - Advances exactly once per accepted bit; holds otherwise.
//  Accept (bit_valid=1, seed_load=0):
//   - p = bit_in ^ ks; p written to shift reg position bit_cnt; bit_cnt++
//  Word completion:
//   - On the accept where bit_cnt == DATA_W-1, the word is complete and bit_cnt wraps to 0.
//   - Next cycle: byte_out = word, byte_valid=1 (1-cycle latency from the last bit).
//  Handshake:
//   - A transfer occurs when byte_valid & out_ready; byte_valid then drops next cycle
//     unless a new word completes in the same cycle.
//   - byte_out is stable while byte_valid=1 and out_ready=0.
//  Simultaneous completion + transfer: the new word loads, byte_valid stays 1, no overrun.
//  Completion while holding (byte_valid=1, out_ready=0):
//   - New word is dropped and overrun is set.
//   - Held byte is unchanged; the LFSR still advances, so keystream sync is kept.
//  seed_load=1:
//   - lfsr = (seed_in==0) ? SEED_DEFAULT : seed_in
//   - bit_cnt=0, partial word discarded, overrun=0
//   - A bit_valid in the same cycle is ignored (no LFSR step).
//   - byte_valid/byte_out are unaffected; a pending word remains available.
//  Reset mid-word or mid-handshake: immediate return to reset values; no partial output.
//  bit_valid may be asserted on consecutive cycles; the block never stalls input.
// TESTING
//  1 Reset, send 0xA5 LSB-first (8 consecutive bits) -> byte_out=0xA5, byte_valid=1
//    one cycle after the 8th bit (first 8 keystream bits are 0).
//  2 After test 1, send 8 zero bits -> second word 0x39 (keystream 1,0,0,1,1,1,0,0).
//  3 Hold out_ready=0 and complete two words -> first word held, overrun=1,
//    third word still decrypts correctly (keystream in sync).
//  4 seed_load with seed_in=0 after 3 bits -> partial discarded, lfsr=0x009C,
//    next 8 bits of 0xA5 -> 0xA5.
//  5 Word completes in the same cycle as out_ready=1 on a held byte -> back-to-back
//    bytes, byte_valid stays 1, overrun=0.
//  6 Drive reset low mid-word and mid-handshake -> all outputs 0 asynchronously;
//    then a 1000-byte loopback against the reference encoder model matches with overrun=0.

Source files
------------

// File: rtl/lfsr_stream_decoder.sv
// Receive-side keystream decryptor: XORs the serial link stream with a 16-bit LFSR
// and packs plaintext bits LSB-first into words behind a 1-entry valid/ready register.
module lfsr_stream_decoder #(
  parameter logic [15:0] SEED_DEFAULT = 16'h009C,
  parameter int          DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [15:0]       seed_in,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [15:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  logic              accept;
  logic              plain;
  logic              feedback;
  logic              complete;
  logic              transfer;
  logic [DATA_W-1:0] word;

  // A bit arriving together with seed_load belongs to the old keystream and is dropped.
  assign accept   = bit_valid & ~seed_load;
  assign plain    = bit_in ^ lfsr_q[15];
  assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign complete = accept && (bit_cnt_q == LAST_CNT);
  assign transfer = valid_q & out_ready;

  always_comb begin
    lfsr_d    = lfsr_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    word      = shift_q;
    word[bit_cnt_q] = plain;

    if (seed_load) begin
      lfsr_d    = (seed_in == 16'h0000) ? SEED_DEFAULT : seed_in;
      bit_cnt_d = '0;
      shift_d   = '0;
      overrun_d = 1'b0;
    end else if (accept) begin
      lfsr_d = {lfsr_q[14:0], feedback};
      if (complete) begin
        bit_cnt_d = '0;
        shift_d   = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        shift_d   = word;
      end
    end

    if (transfer) begin
      valid_d = 1'b0;
    end

    // The output slot is free if empty or being drained this cycle; otherwise drop.
    if (complete) begin
      if (!valid_q || out_ready) begin
        byte_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q    <= SEED_DEFAULT;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_lfsr_stream_decoder.sv
// Bench for lfsr_stream_decoder: vector table, directed corner sequences, and a
// randomized 1000-byte loopback through a keystream encoder model.
module tb_lfsr_stream_decoder;

  localparam logic [15:0] SEED = 16'h009C;
  localparam int NBYTES = 1000;

  logic        clk;
  logic        reset;
  logic        seedLoad;
  logic [15:0] seedIn;
  logic        bitValid;
  logic        bitIn;
  logic        outReady;
  logic [7:0]  byteOut;
  logic        byteValid;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  logic [15:0] encLfsr;

  typedef struct {
    logic       bv;
    logic       bitIn;
    logic       rdy;
    logic [7:0] expByte;
    logic       expValid;
    logic       expOvr;
  } vec_t;

  vec_t vecs[17];

  lfsr_stream_decoder #(.SEED_DEFAULT(SEED), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .seed_load  (seedLoad),
    .seed_in    (seedIn),
    .bit_valid  (bitValid),
    .bit_in     (bitIn),
    .out_ready  (outReady),
    .byte_out   (byteOut),
    .byte_valid (byteValid),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic applyStimulus(input logic sl, input logic [15:0] sd, input logic bv,
                               input logic b, input logic rdy);
    seedLoad = sl;
    seedIn   = sd;
    bitValid = bv;
    bitIn    = b;
    outReady = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eb, input logic ev,
                             input logic eo, input bit cmpByte);
    bit bad;
    bad = 0;
    checks++;
    if (byteValid !== ev) bad = 1;
    if (overrun !== eo) bad = 1;
    if (cmpByte && (byteOut !== eb)) bad = 1;
    if (bad) begin
      errors++;
      $display("[TB] FAIL %s: got byte_out=%h byte_valid=%b overrun=%b, expected byte_out=%h byte_valid=%b overrun=%b",
               name, byteOut, byteValid, overrun, eb, ev, eo);
    end
  endtask

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic setIdle();
    seedLoad = 1'b0;
    seedIn   = 16'h0000;
    bitValid = 1'b0;
    bitIn    = 1'b0;
    outReady = 1'b0;
  endtask

  task automatic doReset();
    setIdle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    encLfsr = SEED;
  endtask

  // Reset dropped between edges: outputs must clear before any clock edge occurs.
  task automatic asyncResetCheck(input string name);
    setIdle();
    #2;
    reset = 1'b0;
    #1;
    checkOutput(name, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    encLfsr = SEED;
  endtask

  task automatic sendPlainBit(input logic p, input logic rdy);
    applyStimulus(1'b0, 16'h0000, 1'b1, p ^ encLfsr[15], rdy);
    encLfsr = lfsrStep(encLfsr);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic rdy);
    for (int i = 0; i < 8; i++) sendPlainBit(b[i], rdy);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [7:0]  a5;
    logic [7:0]  q;
    logic [7:0]  cur;
    logic [7:0]  plainBytes[NBYTES];
    logic [7:0]  expQ[$];
    logic        rdy;
    logic        bv;
    logic        cb;
    int          sentBits;
    int          got;
    int          held;
    int          cyc;

    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) vecs[i] = '{1'b1, a5[i], 1'b0, 8'hA5, (i == 7), 1'b0};
    for (int i = 8; i < 16; i++) vecs[i] = '{1'b1, 1'b0, 1'b1, 8'h39, (i == 15), 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h39, 1'b0, 1'b0};

    doReset();
    checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b1);

    // First 16 keystream bits are the seed MSB-first: eight zeros, then 1,0,0,1,1,1,0,0.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 16'h0000, vecs[i].bv, vecs[i].bitIn, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].expByte, vecs[i].expValid,
                  vecs[i].expOvr, vecs[i].expValid);
    end

    doReset();
    sendByte(8'h11, 1'b0);
    checkOutput("hold_first", 8'h11, 1'b1, 1'b0, 1'b1);
    sendByte(8'h22, 1'b0);
    checkOutput("overrun_set", 8'h11, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checkOutput("drain_held", 8'h00, 1'b0, 1'b1, 1'b0);
    sendByte(8'h33, 1'b0);
    checkOutput("third_in_sync", 8'h33, 1'b1, 1'b1, 1'b1);

    sendPlainBit(1'b1, 1'b0);
    sendPlainBit(1'b1, 1'b0);
    sendPlainBit(1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
    encLfsr = SEED;
    checkOutput("seed_zero_keeps_pending", 8'h33, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checkOutput("drain_after_seed", 8'h00, 1'b0, 1'b0, 1'b0);
    sendByte(8'hA5, 1'b1);
    checkOutput("after_seed_zero", 8'hA5, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    encLfsr = 16'hBEEF;
    checkOutput("seed_beef_drain", 8'h00, 1'b0, 1'b0, 1'b0);
    sendByte(8'h3C, 1'b1);
    checkOutput("after_seed_beef", 8'h3C, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    sendByte(8'h6B, 1'b0);
    checkOutput("b2b_held", 8'h6B, 1'b1, 1'b0, 1'b1);
    q = 8'hD2;
    for (int i = 0; i < 7; i++) sendPlainBit(q[i], 1'b0);
    checkOutput("b2b_stable", 8'h6B, 1'b1, 1'b0, 1'b1);
    sendPlainBit(q[7], 1'b1);
    checkOutput("b2b_second", 8'hD2, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checkOutput("b2b_drain", 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) sendPlainBit(i[0], 1'b1);
    asyncResetCheck("reset_mid_word");
    sendByte(8'h5A, 1'b0);
    checkOutput("pre_reset_held", 8'h5A, 1'b1, 1'b0, 1'b1);
    asyncResetCheck("reset_mid_handshake");
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checkOutput("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b1);

    // Loopback: host stalls randomly but never long enough to lose a word.
    for (int i = 0; i < NBYTES; i++) begin
      plainBytes[i] = 8'($urandom);
      expQ.push_back(plainBytes[i]);
    end
    sentBits = 0;
    got = 0;
    held = 0;
    cyc = 0;
    while (got < NBYTES && cyc < 40000) begin
      rdy = (held >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      if (byteValid && rdy) begin
        if (expQ.size() == 0) begin
          checkVal("loopback_extra", 16'(byteOut), 16'hFFFF);
        end else begin
          checkVal($sformatf("loopback%0d", got), 16'(byteOut), 16'(expQ.pop_front()));
        end
        got++;
      end
      held = (byteValid && !rdy) ? held + 1 : 0;
      bv = (sentBits < NBYTES * 8) && ($urandom_range(0, 3) != 0);
      cb = 1'b0;
      if (bv) begin
        cur = plainBytes[sentBits / 8];
        cb = cur[sentBits % 8] ^ encLfsr[15];
        encLfsr = lfsrStep(encLfsr);
        sentBits++;
      end
      applyStimulus(1'b0, 16'h0000, bv, cb, rdy);
      cyc++;
    end
    checkVal("loopback_count", 16'(got), 16'(NBYTES));
    checkVal("loopback_overrun", 16'(overrun), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
